// File: rtl/js_dir_cmd.sv
// rtl/js_dir_cmd.sv - joystick/button direction requests, filtered into a 2-entry queue
// and applied one per game tick.
module js_dir_cmd #(
  parameter logic [11:0] CENTER    = 12'd2048,
  parameter logic [11:0] ON_DEV    = 12'd900,
  parameter logic [11:0] OFF_DEV   = 12'd600,
  parameter logic [1:0]  RESET_DIR = 2'b11
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic [3:0]  btn_dir_d,
  input  logic [11:0] joy_x,
  input  logic [11:0] joy_y,
  input  logic        tick,
  output logic [1:0]  direction,
  output logic        dir_applied,
  output logic [1:0]  queue_cnt,
  output logic        stick_active
);

  logic [11:0]        jx_r, jy_r;
  logic               j_vld;
  logic signed [12:0] dx, dy;
  logic [12:0]        adx, ady, dom_abs;
  // zone = {active, dir}; dir uses the same encoding as direction
  logic [2:0]         zone, dom_zone, zone_nxt;
  logic               stick_req;
  logic [1:0]         stick_dir;
  logic               req_vld;
  logic [1:0]         req_dir;
  logic [1:0]         q0, q1;
  logic [1:0]         ref_dir;
  logic               pop, accept, push;

  always_comb begin
    dx  = $signed({1'b0, jx_r}) - $signed({1'b0, CENTER});
    dy  = $signed({1'b0, jy_r}) - $signed({1'b0, CENTER});
    adx = dx[12] ? $unsigned(-dx) : $unsigned(dx);
    ady = dy[12] ? $unsigned(-dy) : $unsigned(dy);
    if (adx >= ady) begin
      dom_abs  = adx;
      dom_zone = {1'b1, dx[12] ? 2'b01 : 2'b11};
    end else begin
      dom_abs  = ady;
      dom_zone = {1'b1, dy[12] ? 2'b00 : 2'b10};
    end
    // Between OFF_DEV and ON_DEV the current zone is held (hysteresis).
    zone_nxt = zone;
    if (dom_abs > {1'b0, ON_DEV})
      zone_nxt = dom_zone;
    else if (dom_abs < {1'b0, OFF_DEV})
      zone_nxt = 3'b000;
  end

  always_comb begin
    req_vld = 1'b1;
    req_dir = 2'b00;
    if (btn_dir_d[0])      req_dir = 2'b00;
    else if (btn_dir_d[1]) req_dir = 2'b01;
    else if (btn_dir_d[2]) req_dir = 2'b10;
    else if (btn_dir_d[3]) req_dir = 2'b11;
    else begin
      req_vld = stick_req;
      req_dir = stick_dir;
    end
  end

  // The newest entry is the reference whether or not a pop happens this cycle:
  // with one entry the popped head becomes the new direction anyway.
  always_comb begin
    pop = tick && (queue_cnt != 2'd0);
    if (queue_cnt == 2'd2)      ref_dir = q1;
    else if (queue_cnt == 2'd1) ref_dir = q0;
    else                        ref_dir = direction;
    accept = req_vld && (req_dir != ref_dir) && (req_dir != (ref_dir ^ 2'b10));
    push   = accept && ((queue_cnt != 2'd2) || pop);
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      jx_r         <= '0;
      jy_r         <= '0;
      j_vld        <= 1'b0;
      zone         <= 3'b000;
      stick_active <= 1'b0;
      stick_req    <= 1'b0;
      stick_dir    <= 2'b00;
      q0           <= 2'b00;
      q1           <= 2'b00;
      queue_cnt    <= 2'd0;
      direction    <= RESET_DIR;
      dir_applied  <= 1'b0;
    end else begin
      jx_r      <= joy_x;
      jy_r      <= joy_y;
      j_vld     <= 1'b1;
      stick_req <= 1'b0;
      if (j_vld) begin
        zone         <= zone_nxt;
        stick_active <= zone_nxt[2];
        stick_req    <= zone_nxt[2] && (zone_nxt != zone);
        stick_dir    <= zone_nxt[1:0];
      end

      dir_applied <= pop;
      if (pop) direction <= q0;

      if (pop && push) begin
        if (queue_cnt == 2'd2) begin
          q0 <= q1;
          q1 <= req_dir;
        end else begin
          q0 <= req_dir;
        end
      end else if (pop) begin
        q0        <= q1;
        queue_cnt <= queue_cnt - 2'd1;
      end else if (push) begin
        if (queue_cnt == 2'd0) q0 <= req_dir;
        else                   q1 <= req_dir;
        queue_cnt <= queue_cnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_js_dir_cmd.sv
// tb/tb_js_dir_cmd.sv - scenario bench for js_dir_cmd with an expected-direction queue.
module tb_js_dir_cmd;

  logic        vga_clk = 1'b0;
  logic        reset;
  logic [3:0]  btn_dir_d;
  logic [11:0] joy_x, joy_y;
  logic        tick;
  logic [1:0]  direction;
  logic        dir_applied;
  logic [1:0]  queue_cnt;
  logic        stick_active;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [1:0] exp_q[$];
  logic [1:0] cur_dir;

  js_dir_cmd dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .btn_dir_d   (btn_dir_d),
    .joy_x       (joy_x),
    .joy_y       (joy_y),
    .tick        (tick),
    .direction   (direction),
    .dir_applied (dir_applied),
    .queue_cnt   (queue_cnt),
    .stick_active(stick_active)
  );

  always #20 vga_clk = ~vga_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge vga_clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] b);
    btn_dir_d = b;
    cyc();
    btn_dir_d = 4'b0000;
  endtask

  task automatic apply_tick(input string tag);
    logic [1:0] e;
    logic       has;
    has = (exp_q.size() > 0);
    e   = has ? exp_q.pop_front() : cur_dir;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    n_tests++;
    if (dir_applied !== has) begin
      n_fail++;
      $display("FAIL %s dir_applied: got %b expected %b", tag, dir_applied, has);
    end
    n_tests++;
    if (direction !== e) begin
      n_fail++;
      $display("FAIL %s direction: got %b expected %b", tag, direction, e);
    end
    cur_dir = e;
    cyc();
    n_tests++;
    if (dir_applied !== 1'b0) begin
      n_fail++;
      $display("FAIL %s dir_applied_pulse: got %b expected 0", tag, dir_applied);
    end
    n_tests++;
    if (queue_cnt !== 2'(exp_q.size())) begin
      n_fail++;
      $display("FAIL %s queue_cnt_after_tick: got %0d expected %0d", tag, queue_cnt, exp_q.size());
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    btn_dir_d = 4'b0000;
    tick = 1'b0;
    joy_x = 12'd2048;
    joy_y = 12'd2048;
    cyc(3);
    reset = 1'b0;
    exp_q.delete();
    cur_dir = 2'b11;
    n_tests++;
    if ({direction, dir_applied, queue_cnt, stick_active} !== {2'b11, 1'b0, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got dir=%b app=%b cnt=%0d act=%b expected dir=11 app=0 cnt=0 act=0",
               direction, dir_applied, queue_cnt, stick_active);
    end
    cyc(3);
    n_tests++;
    if (queue_cnt !== 2'd0 || stick_active !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got cnt=%0d act=%b expected 0 0", queue_cnt, stick_active);
    end
  endtask

  task automatic test_basic_apply;
    press(4'b0001);
    exp_q.push_back(2'b00);
    n_tests++;
    if (queue_cnt !== 2'd1) begin
      n_fail++;
      $display("FAIL basic_enqueue: got cnt=%0d expected 1", queue_cnt);
    end
    cyc(4);
    n_tests++;
    if (direction !== 2'b11 || dir_applied !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_hold: got dir=%b app=%b expected 11 0", direction, dir_applied);
    end
    apply_tick("basic_apply");
  endtask

  task automatic test_filter;
    press(4'b0100);
    n_tests++;
    if (queue_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL filter_reversal: got cnt=%0d expected 0", queue_cnt);
    end
    press(4'b0001);
    n_tests++;
    if (queue_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL filter_noop: got cnt=%0d expected 0", queue_cnt);
    end
    apply_tick("filter_tick1");
    apply_tick("filter_tick2");
  endtask

  task automatic test_back_to_back;
    press(4'b1000);
    exp_q.push_back(2'b11);
    apply_tick("b2b_setup");
    btn_dir_d = 4'b0001; cyc();
    btn_dir_d = 4'b0010; cyc();
    btn_dir_d = 4'b0100; cyc();
    btn_dir_d = 4'b0000;
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b01);
    n_tests++;
    if (queue_cnt !== 2'd2) begin
      n_fail++;
      $display("FAIL b2b_full: got cnt=%0d expected 2", queue_cnt);
    end
    apply_tick("b2b_first");
    apply_tick("b2b_second");
    apply_tick("b2b_dropped_not_applied");
  endtask

  task automatic test_priority;
    press(4'b0001);
    exp_q.push_back(2'b00);
    apply_tick("prio_setup");
    joy_y = 12'd1048;
    cyc(2);
    btn_dir_d = 4'b1010;
    cyc();
    btn_dir_d = 4'b0000;
    exp_q.push_back(2'b01);
    joy_y = 12'd2048;
    n_tests++;
    if (queue_cnt !== 2'd1) begin
      n_fail++;
      $display("FAIL prio_enqueue: got cnt=%0d expected 1", queue_cnt);
    end
    cyc(4);
    n_tests++;
    if (queue_cnt !== 2'd1) begin
      n_fail++;
      $display("FAIL prio_stick_dropped: got cnt=%0d expected 1", queue_cnt);
    end
    apply_tick("prio_apply");
  endtask

  task automatic test_stick;
    press(4'b0001);
    exp_q.push_back(2'b00);
    apply_tick("stick_setup");
    joy_x = 12'd1048;
    cyc(2);
    n_tests++;
    if (queue_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL stick_latency_early: got cnt=%0d expected 0", queue_cnt);
    end
    cyc();
    exp_q.push_back(2'b01);
    n_tests++;
    if (stick_active !== 1'b1 || queue_cnt !== 2'd1) begin
      n_fail++;
      $display("FAIL stick_enter: got act=%b cnt=%0d expected 1 1", stick_active, queue_cnt);
    end
    joy_x = 12'd1348;
    cyc(5);
    n_tests++;
    if (stick_active !== 1'b1 || queue_cnt !== 2'd1) begin
      n_fail++;
      $display("FAIL stick_hold: got act=%b cnt=%0d expected 1 1", stick_active, queue_cnt);
    end
    joy_x = 12'd1548;
    cyc(2);
    n_tests++;
    if (stick_active !== 1'b0 || queue_cnt !== 2'd1) begin
      n_fail++;
      $display("FAIL stick_release: got act=%b cnt=%0d expected 0 1", stick_active, queue_cnt);
    end
    joy_x = 12'd2048;
    apply_tick("stick_apply");
  endtask

  task automatic test_full_pop_push;
    press(4'b0001);
    press(4'b1000);
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b11);
    n_tests++;
    if (queue_cnt !== 2'd2) begin
      n_fail++;
      $display("FAIL fpp_full: got cnt=%0d expected 2", queue_cnt);
    end
    tick = 1'b1;
    btn_dir_d = 4'b0001;
    cyc();
    tick = 1'b0;
    btn_dir_d = 4'b0000;
    n_tests++;
    if (direction !== exp_q[0] || dir_applied !== 1'b1 || queue_cnt !== 2'd2) begin
      n_fail++;
      $display("FAIL fpp_pop_push: got dir=%b app=%b cnt=%0d expected %b 1 2",
               direction, dir_applied, queue_cnt, exp_q[0]);
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    exp_q.delete();
    cur_dir = 2'b11;
    n_tests++;
    if (queue_cnt !== 2'd0 || direction !== 2'b11 || dir_applied !== 1'b0) begin
      n_fail++;
      $display("FAIL fpp_reset: got cnt=%0d dir=%b app=%b expected 0 11 0",
               queue_cnt, direction, dir_applied);
    end
    cyc(2);
    apply_tick("fpp_after_reset");
  endtask

  initial begin
    test_reset();
    test_basic_apply();
    test_filter();
    test_back_to_back();
    test_priority();
    test_stick();
    test_full_pop_push();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
